// File: rtl/request_unit_if.sv
// Control-unit strobes in, memory requests and commit strobe out,
// shared by the request sequencer and whatever drives it.
interface request_unit_if;
   logic ihit;
   logic dhit;
   logic dRENi;
   logic dWENi;
   logic halt;
   logic imemREN;
   logic dmemREN;
   logic dmemWEN;
   logic pcEN;
   logic halted;

   modport master (
      input  ihit, dhit, dRENi, dWENi, halt,
      output imemREN, dmemREN, dmemWEN, pcEN, halted
   );

   modport slave (
      output ihit, dhit, dRENi, dWENi, halt,
      input  imemREN, dmemREN, dmemWEN, pcEN, halted
   );
endinterface

// File: rtl/request_unit.sv
// Fetch / data / halt request sequencer with a one-cycle pcEN commit.
// REQUEST_UNIT_PERF_EN adds saturating retire and data-stall counters.
module request_unit #(
  parameter int CNT_W = 32
) (
  input logic            CLK,
  input logic            nRST,
  request_unit_if.master ru
`ifdef REQUEST_UNIT_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] dstall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    HALT
  } state_t;

  state_t state;
  logic   rd_q;
  logic   wr_q;
  logic   pc_en;
  logic   mem_op;

  assign mem_op = ru.dRENi | ru.dWENi;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (ru.ihit) begin
            if (ru.halt) begin
              state <= HALT;
            end else if (mem_op) begin
              state <= DATA;
              wr_q  <= ru.dWENi;
              rd_q  <= ru.dRENi & ~ru.dWENi;
            end
          end
        end
        DATA: begin
          if (ru.dhit) begin
            state <= FETCH;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end

  assign pc_en = ((state == FETCH) & ru.ihit
                  & ~ru.halt & ~mem_op)
               | ((state == DATA) & ru.dhit);

  assign ru.pcEN    = pc_en;
  assign ru.imemREN = (state == FETCH);
  assign ru.dmemREN = (state == DATA) & rd_q;
  assign ru.dmemWEN = (state == DATA) & wr_q;
  assign ru.halted  = (state == HALT);

`ifdef REQUEST_UNIT_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_cnt  <= '0;
      dstall_cnt <= '0;
    end else begin
      if (pc_en && !(&instr_cnt))
        instr_cnt <= instr_cnt + 1'b1;
      if ((state == DATA) && !ru.dhit
          && !(&dstall_cnt))
        dstall_cnt <= dstall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed vector table, corner sequences,
// and random traffic against a transaction-level model.
module tb_request_unit;

  logic CLK;
  logic nRST;

  request_unit_if ru ();

`ifdef REQUEST_UNIT_PERF_EN
  logic [31:0] instr_cnt;
  logic [31:0] dstall_cnt;
`endif

  request_unit #(.CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ru   (ru)
`ifdef REQUEST_UNIT_PERF_EN
    ,
    .instr_cnt  (instr_cnt),
    .dstall_cnt (dstall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic i, d, r, w, h;
    logic imem, drd, dwr, pc, hlt;
  } vec_t;

  bit boot;
  bit pend_rd;
  bit pend_wr;
  bit halted_m;
  int icnt;
  int scnt;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    boot     = 1'b1;
    pend_rd  = 1'b0;
    pend_wr  = 1'b0;
    halted_m = 1'b0;
    icnt     = 0;
    scnt     = 0;
  endtask

  function automatic bit m_fetching();
    return nRST && !boot && !pend_rd
        && !pend_wr && !halted_m;
  endfunction

  function automatic bit m_pc();
    bit pend;
    pend = nRST && (pend_rd || pend_wr);
    return (m_fetching() && ru.ihit && !ru.halt
            && !ru.dRENi && !ru.dWENi)
        || (pend && ru.dhit);
  endfunction

  task automatic model_step();
    bit pend;
    if (!nRST) begin
      model_reset();
    end else begin
      pend = pend_rd || pend_wr;
      if (m_pc()) icnt++;
      if (pend && !ru.dhit) scnt++;
      if (halted_m) begin
      end else if (boot) begin
        boot = 1'b0;
      end else if (pend) begin
        if (ru.dhit) begin
          pend_rd = 1'b0;
          pend_wr = 1'b0;
        end
      end else if (ru.ihit) begin
        if (ru.halt) begin
          halted_m = 1'b1;
        end else if (ru.dRENi || ru.dWENi) begin
          pend_wr = ru.dWENi;
          pend_rd = ru.dRENi && !ru.dWENi;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("imemREN", 32'(ru.imemREN), 32'(m_fetching()));
    chk("dmemREN", 32'(ru.dmemREN), 32'(nRST && pend_rd));
    chk("dmemWEN", 32'(ru.dmemWEN), 32'(nRST && pend_wr));
    chk("pcEN", 32'(ru.pcEN), 32'(m_pc()));
    chk("halted", 32'(ru.halted), 32'(nRST && halted_m));
`ifdef REQUEST_UNIT_PERF_EN
    chk("instr_cnt", instr_cnt, 32'(icnt));
    chk("dstall_cnt", dstall_cnt, 32'(scnt));
`endif
  endtask

  task automatic drive(logic i, logic d, logic r,
                       logic w, logic h);
    ru.ihit  = i;
    ru.dhit  = d;
    ru.dRENi = r;
    ru.dWENi = w;
    ru.halt  = h;
  endtask

  task automatic cyc(logic i, logic d, logic r,
                     logic w, logic h);
    drive(i, d, r, w, h);
    @(negedge CLK);
    check_model();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst_imem", 32'(ru.imemREN), 32'd0);
      chk("rst_pc", 32'(ru.pcEN | ru.halted), 32'd0);
      @(posedge CLK);
      #1;
    end
    nRST = 1'b1;
  endtask

  function automatic vec_t mk(logic i, logic d, logic r,
                              logic w, logic h, logic imem,
                              logic drd, logic dwr,
                              logic pc, logic hlt);
    vec_t v;
    v.i = i; v.d = d; v.r = r; v.w = w; v.h = h;
    v.imem = imem; v.drd = drd; v.dwr = dwr;
    v.pc = pc; v.hlt = hlt;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST  = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("async_rst_imem", 32'(ru.imemREN), 32'd0);
    @(posedge CLK);
    #1;

    tbl[0]  = mk(0,0,0,0,0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1,0,0,0,0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(1,0,0,0,0, 1, 0, 0, 1, 0);
    tbl[3]  = mk(1,0,0,0,0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1,0,0,0,0, 1, 0, 0, 1, 0);
    tbl[5]  = mk(1,0,1,0,0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1,0,0,0,0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0,0,0,0,0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0,1,0,0,0, 0, 1, 0, 1, 0);
    tbl[9]  = mk(0,0,0,0,0, 1, 0, 0, 0, 0);
    tbl[10] = mk(1,0,1,1,0, 1, 0, 0, 0, 0);
    tbl[11] = mk(0,1,0,0,0, 0, 0, 1, 1, 0);
    tbl[12] = mk(0,1,0,0,0, 1, 0, 0, 0, 0);
    tbl[13] = mk(1,0,1,0,1, 1, 0, 0, 0, 0);
    tbl[14] = mk(1,1,0,0,0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0,1,1,1,1, 0, 0, 0, 0, 1);

    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].i, tbl[k].d, tbl[k].r,
            tbl[k].w, tbl[k].h);
      @(negedge CLK);
      chk($sformatf("v%0d_imem", k),
          32'(ru.imemREN), 32'(tbl[k].imem));
      chk($sformatf("v%0d_drd", k),
          32'(ru.dmemREN), 32'(tbl[k].drd));
      chk($sformatf("v%0d_dwr", k),
          32'(ru.dmemWEN), 32'(tbl[k].dwr));
      chk($sformatf("v%0d_pc", k),
          32'(ru.pcEN), 32'(tbl[k].pc));
      chk($sformatf("v%0d_hlt", k),
          32'(ru.halted), 32'(tbl[k].hlt));
      model_step();
      @(posedge CLK);
      #1;
    end
`ifdef REQUEST_UNIT_PERF_EN
    @(negedge CLK);
    chk("tbl_instr_cnt", instr_cnt, 32'd6);
    chk("tbl_dstall_cnt", dstall_cnt, 32'd2);
    @(posedge CLK);
    #1;
`endif

    for (int k = 0; k < 10; k++)
      cyc(k[0], ~k[0], k[1], k[2], 1'b0);

    do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mid_wen_before", 32'(ru.dmemWEN), 32'd1);
    nRST = 1'b0;
    model_reset();
    #1;
    chk("mid_wen_drop", 32'(ru.dmemWEN), 32'd0);
    @(posedge CLK);
    #1;
    cyc(0, 1, 0, 0, 0);
    nRST = 1'b1;
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("mid_no_replay", 32'(ru.dmemWEN), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        nRST = 1'b0;
        model_reset();
      end else begin
        nRST = 1'b1;
      end
      cyc(1'($urandom_range(0, 99) < 60),
          1'($urandom_range(0, 99) < 40),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 79) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
